// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with misprediction history restore and a one-cycle flush sequencer.
module branch_predictor #(
    parameter int PATTERN_WIDTH  = 4,
    parameter int INST_MEM_WIDTH = 14,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lookup_valid,
    output logic                      lookup_ready,
    input  logic [INST_MEM_WIDTH-1:0] lookup_pc,
    output logic                      prediction,
    output logic [PATTERN_WIDTH-1:0]  pattern_out,
    input  logic                      commit_valid,
    input  logic [INST_MEM_WIDTH-1:0] commit_pc,
    input  logic [PATTERN_WIDTH-1:0]  commit_pattern,
    input  logic                      commit_taken,
    input  logic                      commit_failure,
    output logic                      flush,
    output logic [STAT_WIDTH-1:0]     branch_count,
    output logic [STAT_WIDTH-1:0]     miss_count
);
    localparam int PW = PATTERN_WIDTH;
    localparam int ENTRIES = 1 << PW;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state, state_next;
    logic [1:0]    pht [ENTRIES];
    logic [PW-1:0] ghr, ghr_next, idx, train_idx;
    logic [1:0]    train_cnt, train_next;
    logic          fail, accept, unused_bits;

    assign idx          = lookup_pc[PW-1:0] ^ ghr;
    assign train_idx    = commit_pc[PW-1:0] ^ commit_pattern;
    assign prediction   = pht[idx][1];
    assign pattern_out  = ghr;
    assign flush        = state == FLUSH;
    assign lookup_ready = !flush;
    assign fail         = commit_valid && commit_failure;
    assign accept       = lookup_valid && lookup_ready;
    assign train_cnt    = pht[train_idx];
    assign unused_bits  = ^{lookup_pc[INST_MEM_WIDTH-1:PW], commit_pc[INST_MEM_WIDTH-1:PW]};

    always_comb begin
        state_next = state;
        state_next = (state == FLUSH) ? RUN : (fail ? FLUSH : RUN);
        // A failing commit restores history and wins over a same-cycle lookup shift
        ghr_next   = fail ? {commit_pattern[PW-2:0], commit_taken}
                          : (accept ? {ghr[PW-2:0], prediction} : ghr);
        train_next = commit_taken ? ((train_cnt == 2'b11) ? train_cnt : train_cnt + 2'd1)
                                  : ((train_cnt == 2'b00) ? train_cnt : train_cnt - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            ghr          <= '0;
            branch_count <= '0;
            miss_count   <= '0;
            for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
        end else begin
            state <= state_next;
            ghr   <= ghr_next;
            if (commit_valid) begin
                pht[train_idx] <= train_next;
                if (!(&branch_count)) branch_count <= branch_count + STAT_WIDTH'(1);
                if (commit_failure && !(&miss_count)) miss_count <= miss_count + STAT_WIDTH'(1);
            end
        end
    end
endmodule
